// File: rtl/regbank_reader_if.sv
// Output word stream of regbank_reader: captured register value, its address,
// and a valid/ready handshake.
interface regbank_reader_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output out_data,
      output out_addr,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_addr,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/regbank_reader.sv
// Burst reader: fetches count consecutive registers (wrapping) from a bank
// and streams them out. Optional XOR checksum under REGBANK_READER_CHKSUM_EN.
module regbank_reader #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     count,
   output logic [ADDR_W-1:0]   rb_read_addr,
   input  logic [DATA_W-1:0]   rb_read_data,
   regbank_reader_if.master    stream,
   output logic                busy,
   output logic                done
`ifdef REGBANK_READER_CHKSUM_EN
   ,
   output logic [DATA_W-1:0]   chksum
`endif
);

   localparam int unsigned    DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W:0] MAX_COUNT = DEPTH[ADDR_W:0];

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SEND,
      DONE
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [ADDR_W-1:0]   pointer;
   logic [ADDR_W:0]     remaining;
   logic [DATA_W-1:0]   data_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                transfer;

   assign transfer = (state == SEND) && stream.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = (count == '0) ? DONE : FETCH;
            end
         end
         FETCH: next_state = SEND;
         SEND: begin
            if (stream.out_ready) begin
               next_state = (remaining > 1) ? FETCH : DONE;
            end
         end
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Requests above the bank size are clamped so a burst never re-reads a register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pointer   <= '0;
         remaining <= '0;
         data_q    <= '0;
         addr_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  pointer   <= base_addr;
                  remaining <= (count > MAX_COUNT) ? MAX_COUNT : count;
               end
            end
            FETCH: begin
               data_q <= rb_read_data;
               addr_q <= pointer;
            end
            SEND: begin
               if (stream.out_ready) begin
                  remaining <= remaining - 1'b1;
                  pointer   <= pointer + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef REGBANK_READER_CHKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chksum <= '0;
      end else if ((state == IDLE) && start) begin
         chksum <= '0;
      end else if (transfer) begin
         chksum <= chksum ^ data_q;
      end
   end
`endif

   assign rb_read_addr     = pointer;
   assign stream.out_data  = data_q;
   assign stream.out_addr  = addr_q;
   assign stream.out_valid = (state == SEND);
   assign busy             = (state != IDLE);
   assign done             = (state == DONE);

endmodule
